// File: rtl/ascii_tolower_stream.sv
// ascii_tolower_stream
//   Streaming ASCII lowercase converter with a DEPTH-entry FIFO between a
//   valid/ready producer and a valid/ready consumer. Each accepted byte is
//   converted on push when en=1. 'A'..'Z' gain bit 5. All other bytes are
//   stored unchanged. A saturating counter tracks how many bytes were
//   actually changed.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   en                   1 = convert on push, 0 = bypass (not counted)
//   in_data/valid/ready  producer side; in_ready = !full
//   out_data/valid/ready consumer side; out_data is registered head data
//   conv_count, clr_count saturating conversion count; synchronous clear
//   full, empty          FIFO occupancy flags
//
// DEPTH must be a power of two, >= 2.

// Per-byte conversion: pure combinational, sits in front of the FIFO write.
module ascii_tolower_lane (
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       hit
);
  assign hit  = en && (din >= 8'h41) && (din <= 8'h5A);
  assign dout = hit ? (din | 8'h20) : din;
endmodule

module ascii_tolower_stream #(
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] conv_count,
  input  logic          clr_count,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ;
  logic [7:0]    conv_data;
  logic          conv_hit;
  logic          push, pop;

  ascii_tolower_lane u_lane (
    .en   (en),
    .din  (in_data),
    .dout (conv_data),
    .hit  (conv_hit)
  );

  assign full      = (occ == OCC_FULL);
  assign empty     = (occ == '0);
  // Ready is derived from full only, never from out_ready, so a full FIFO
  // refuses a push even in a pop cycle.
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Storage is flops, so the head read is registered data with no in->out
  // combinational path. Entries are cleared on reset so out_data reads 0.
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else if (push) begin
      mem[wr_ptr] <= conv_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Clear wins over a same-cycle increment; count holds at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       conv_count <= '0;
    else if (clr_count)                            conv_count <= '0;
    else if (push && conv_hit && conv_count != CNT_MAX) conv_count <= conv_count + 1'b1;
  end
endmodule

// File: tb/tb_ascii_tolower_stream.sv
module tb_ascii_tolower_stream;
  logic        clk = 1'b0;
  logic        rst;
  logic        en, in_valid, out_ready, clr_count;
  logic [7:0]  in_data;
  logic        in_ready, out_valid, full, empty;
  logic [7:0]  out_data;
  logic [15:0] conv_count;

  // Second instance with a 4-bit counter for saturation checks.
  logic        in_valid4, out_ready4, clr4;
  logic [7:0]  in_data4;
  logic        in_ready4, out_valid4, full4, empty4;
  logic [7:0]  out_data4;
  logic [3:0]  conv4;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  ascii_tolower_stream #(.DEPTH(4), .CW(16)) dut (
    .clk(clk), .rst(rst), .en(en), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .conv_count(conv_count), .clr_count(clr_count),
    .full(full), .empty(empty)
  );

  ascii_tolower_stream #(.DEPTH(4), .CW(4)) dut4 (
    .clk(clk), .rst(rst), .en(1'b1), .in_data(in_data4), .in_valid(in_valid4),
    .in_ready(in_ready4), .out_data(out_data4), .out_valid(out_valid4),
    .out_ready(out_ready4), .conv_count(conv4), .clr_count(clr4),
    .full(full4), .empty(empty4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one edge; sample 1ns after it.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_count = 1'b0;
    in_data = 8'h00; in_valid4 = 1'b0; out_ready4 = 1'b0; clr4 = 1'b0; in_data4 = 8'h00;
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", conv_count, 0);
    rst = 1'b0;

    // 1: mixed bytes, streaming at full rate
    begin
      logic [7:0] vin [6] = '{8'h61, 8'h41, 8'h5A, 8'h40, 8'h5B, 8'h7A};
      logic [7:0] vex [6] = '{8'h61, 8'h61, 8'h7A, 8'h40, 8'h5B, 8'h7A};
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
        in_data = vin[i]; in_valid = 1'b1;
        tick();
        chk("t1_valid", out_valid, 1);
        chk($sformatf("t1_data%0d", i), out_data, vex[i]);
      end
      in_valid = 1'b0;
      tick();
      chk("t1_empty", empty, 1);
      chk("t1_count", conv_count, 2);
    end

    // 2: fill to full, hold a 5th byte, then drain
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'h41 + 8'(i); in_valid = 1'b1;
      tick();
    end
    chk("t2_full", full, 1);
    chk("t2_in_ready", in_ready, 0);
    in_data = 8'h45;
    tick();
    chk("t2_hold", out_data, 8'h61);
    chk("t2_still_full", full, 1);
    out_ready = 1'b1;
    tick();
    chk("t2_pop1", out_data, 8'h62);
    chk("t2_notfull", full, 0);
    tick();
    in_valid = 1'b0;
    chk("t2_pop2", out_data, 8'h63);
    tick();
    chk("t2_pop3", out_data, 8'h64);
    tick();
    chk("t2_pop4", out_data, 8'h65);
    tick();
    chk("t2_empty", empty, 1);
    chk("t2_count", conv_count, 7);

    // clear
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    chk("clr", conv_count, 0);

    // 3: 20 bytes at full rate, pointers wrap 5 times
    for (int i = 0; i < 20; i++) begin
      in_data = 8'h41 + 8'(i); in_valid = 1'b1;
      tick();
      chk($sformatf("t3_v%0d", i), out_valid, 1);
      chk($sformatf("t3_d%0d", i), out_data, 8'h61 + 8'(i));
    end
    in_valid = 1'b0;
    tick();
    chk("t3_empty", empty, 1);
    chk("t3_count", conv_count, 20);

    // 4: en sampled at push only
    out_ready = 1'b0;
    en = 1'b0; in_data = 8'h48; in_valid = 1'b1;
    tick();
    en = 1'b1; in_data = 8'h49;
    tick();
    in_valid = 1'b0; en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    chk("t4_d0", out_data, 8'h48);
    out_ready = 1'b1;
    tick();
    chk("t4_d1", out_data, 8'h69);
    tick();
    chk("t4_empty", empty, 1);
    chk("t4_count", conv_count, 21);

    // 5: saturation and clear priority on the CW=4 instance
    out_ready4 = 1'b1; in_valid4 = 1'b1; in_data4 = 8'h41;
    for (int i = 0; i < 17; i++) tick();
    chk("t5_sat", conv4, 15);
    clr4 = 1'b1;
    tick();
    chk("t5_clr_prio", conv4, 0);
    clr4 = 1'b0; in_valid4 = 1'b0;
    tick();

    // 6: async reset mid-stream
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'h41; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("t6_pre_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_empty", empty, 1);
    chk("t6_rst_count", conv_count, 0);
    #2 rst = 1'b0;
    tick();
    chk("t6_post_valid", out_valid, 0);
    in_data = 8'h51; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t6_data", out_data, 8'h71);
    chk("t6_count", conv_count, 1);
    out_ready = 1'b1;
    tick();
    chk("t6_empty", empty, 1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
